// File: rtl/par2serial_lanes.sv
// Multi-lane parallel-to-serial transmitter for the PHY path at clk_32f.
// Every lane shifts one WIDTH-bit word out MSB first; lanes share one bit counter, so they stay word-aligned.
module par2serial_lanes #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      LANES      = 2,
    parameter logic [WIDTH-1:0] IDLE_SYM   = 8'hBC,
    parameter logic [WIDTH-1:0] ACTIVE_SYM = 8'h7C
) (
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic                     active,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES-1:0]         valid_in,
    input  logic [LANES*WIDTH-1:0]   data_in,
    output logic                     ready,
    output logic                     frame,
    output logic [LANES-1:0]         serial_out,
    output logic [LANES-1:0]         sent_data
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]              cnt_q,   cnt_d;
    logic [LANES-1:0][WIDTH-1:0]   word_q,  word_d;
    logic [LANES-1:0]              sent_q,  sent_d;
    logic [LANES-1:0]              ser_q,   ser_d;
    logic                          frame_q, frame_d;
    logic                          load_s;
    logic [CNT_W-1:0]              bit_idx_s;

    // Word chosen at a boundary: user data wins, otherwise the fill symbol for the link state.
    function automatic logic [WIDTH-1:0] select_word(
        input logic             vld,
        input logic             act,
        input logic [WIDTH-1:0] data
    );
        logic [WIDTH-1:0] w;
        if (vld) begin
            w = data;
        end else if (act) begin
            w = ACTIVE_SYM;
        end else begin
            w = IDLE_SYM;
        end
        return w;
    endfunction

    // Serial bit for one lane; a disabled lane is forced low but keeps its word.
    function automatic logic lane_bit(
        input logic             en,
        input logic [WIDTH-1:0] w,
        input logic [CNT_W-1:0] idx
    );
        logic b;
        if (en) begin
            b = w[idx];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    assign load_s    = (cnt_q == {CNT_W{1'b0}});
    assign bit_idx_s = CNT_MAX - cnt_q;

    // Next-state: counter wrap, word capture at the boundary and the next serial bit per lane.
    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        sent_d  = sent_q;
        ser_d   = {LANES{1'b0}};
        frame_d = 1'b0;

        if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end

        for (int i = 0; i < LANES; i++) begin
            if (load_s) begin
                word_d[i] = select_word(valid_in[i], active, data_in[i*WIDTH +: WIDTH]);
                sent_d[i] = valid_in[i];
                // The MSB comes from the word being loaded, not the one leaving.
                ser_d[i]  = lane_bit(lane_en[i], word_d[i], CNT_MAX);
            end else begin
                ser_d[i]  = lane_bit(lane_en[i], word_q[i], bit_idx_s);
            end
        end

        if (load_s) begin
            frame_d = 1'b1;
        end else begin
            frame_d = 1'b0;
        end
    end

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            cnt_q   <= {CNT_W{1'b0}};
            word_q  <= {(LANES*WIDTH){1'b0}};
            sent_q  <= {LANES{1'b0}};
            ser_q   <= {LANES{1'b0}};
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            sent_q  <= sent_d;
            ser_q   <= ser_d;
            frame_q <= frame_d;
        end
    end

    assign ready      = load_s;
    assign frame      = frame_q;
    assign serial_out = ser_q;
    assign sent_data  = sent_q;

endmodule

// File: doc/par2serial_lanes.md
# par2serial_lanes

Parametrised multi-lane parallel-to-serial converter for the PHY transmit path at clk_32f. Each lane shifts out one WIDTH-bit word per WIDTH clocks, MSB first. A lane sends user data when its valid bit is set at the word boundary. Otherwise it sends a fill symbol: ACTIVE_SYM while the link is active, IDLE_SYM when it is not. The block replaces the single-lane, fixed-8-bit idle generator and adds a data path, a lane count, a per-lane enable and a word-boundary handshake.

## Interface
- WIDTH, 8: bits per word and serial frame length; WIDTH ≥ 2.
- LANES, 2: number of independent serial lanes; LANES ≥ 1.
- IDLE_SYM, 8'hBC: WIDTH-bit fill symbol sent when active=0.
- ACTIVE_SYM, 8'h7C: WIDTH-bit fill symbol sent when active=1 and the lane has no valid data.
- clk_32f  input  1  serial bit clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low.
- active  input  1  link-active flag; selects the fill symbol.
- lane_en  input  LANES  per-lane enable; a disabled lane drives 0.
- valid_in  input  LANES  per-lane data-valid, sampled at the word boundary.
- data_in  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- ready  output  1  combinational, high when cnt==0; inputs are sampled on this clock edge.
- frame  output  1  registered, high while serial_out carries the MSB of a word.
- serial_out  output  LANES  registered serial bit per lane.
- sent_data  output  LANES  registered; lane i's current word is user data rather than fill.

## Operation
- State:
  - bit counter cnt, width clog2(WIDTH), counts 0..WIDTH-1 and wraps to 0.
  - per lane: a WIDTH-bit word register and a data flag.
- Load (edge with reset=1, cnt==0), per lane i:
  - if valid_in[i]: word_i ← data slice i, sent_data[i] ← 1.
  - else if active: word_i ← ACTIVE_SYM, sent_data[i] ← 0.
  - else: word_i ← IDLE_SYM, sent_data[i] ← 0.
  - serial_out[i] ← bit WIDTH-1 of the newly selected word, not of the old register.
  - frame ← 1.
- Shift (edge with reset=1, cnt = k ≠ 0):
  - serial_out[i] ← word_i[WIDTH-1-k].
  - frame ← 0.
- Lane enable: lane_en[i]=0 forces serial_out[i] ← 0 on every edge. The lane's counter phase and word capture continue, so re-enabling takes effect immediately, mid-word if that is where cnt stands.
- Handshake: a transfer on lane i is valid_in[i] & ready. Data presented while ready=0 is ignored and is not latched. Producers hold data and valid until they see ready.
- active, valid_in and data_in changing mid-word have no effect until the next load.
- All lanes share cnt, so they are always word-aligned with each other.

## Timing
- Reset (reset=0 at an edge): cnt=0, serial_out=0, frame=0, sent_data=0, word registers=0.
  - ready=1 during reset because cnt==0. Consumers ignore it while reset=0.
- First load occurs at the first edge with reset=1, so the MSB appears one cycle after reset release.
- Latency: input sampled at load edge t. Bit WIDTH-1 is on serial_out after t, bit 0 after edge t+WIDTH-1. The next load is at t+WIDTH.
- Throughput: one word per lane every WIDTH cycles, with no gap between words.
- ready is high exactly 1 cycle in WIDTH. frame is high exactly 1 cycle in WIDTH and lags ready by one cycle.
- Reset asserted mid-word aborts the word at once. There is no partial-word completion. After release the next word starts at MSB.
- cnt wrap-around: after cnt==WIDTH-1 the next value is 0 regardless of inputs.

## Test plan
- Reset then active=0, valid=0, lane_en=2'b11, WIDTH=8, LANES=2 -> after release both lanes emit 10111100 repeating; frame every 8th cycle; sent_data=0.
- active=1, valid=0 -> both lanes emit 01111100 starting at the first load after active rises; the word already in flight completes unchanged.
- Lane0 data 8'hA5 valid at a ready cycle, lane1 not valid, active=1 -> lane0 emits 10100101 with sent_data[0]=1, lane1 emits 01111100; the following word returns to fill when valid drops.
- valid_in asserted with 8'hFF only while ready=0, dropped before ready -> never transmitted; fill continues.
- lane_en=2'b01 with continuous data -> serial_out[1] held 0 throughout, lane0 unaffected; setting lane_en[1]=1 mid-word outputs the remaining bits of the current word.
- reset pulled low at cnt=4 for one cycle -> serial_out=0 and frame=0 that cycle; MSB of a fresh word appears one cycle after release.
